dmem_access_ctrl: RTL and testbench
===================================

Name: dmem_access_ctrl

Overview:
MEM-stage data-memory access controller for the 5-stage MIPS pipeline. It decodes the load/store opcode and drives byte-lane enables and lane-aligned write data, so the byte/half zero-fill no longer happens upstream. It runs a req/ack handshake to a variable-latency data memory and stalls the pipeline until the access completes or times out. Load data is returned aligned and sign- or zero-extended for the MEM/WB register.

Parameters:
ADDR_W, 32, byte address width
TIMEOUT, 255, max cycles in ACCESS awaiting i_dm_ack before abort (1..255)

Ports:
i_clk  in  1  clock, rising edge
i_reset_n  in  1  asynchronous active-low reset
i_mem_valid  in  1  MEM stage holds a valid instruction
i_opcode  in  6  MEM-stage opcode
i_addr  in  ADDR_W  effective byte address (ALU result)
i_wdata  in  32  store data (rt value)
o_stall  out  1  freeze IF..MEM stages
o_rdata  out  32  extended load result
o_rdata_valid  out  1  o_rdata valid, one-cycle pulse
o_err  out  1  access error, one-cycle pulse
o_dm_req  out  1  memory request, held until ack
o_dm_we  out  1  1 = write
o_dm_be  out  4  byte enables, bit i = byte lane i (little-endian)
o_dm_addr  out  ADDR_W  word-aligned address ({addr[ADDR_W-1:2],2'b00})
o_dm_wdata  out  32  lane-replicated write data
i_dm_ack  in  1  memory completes request this cycle
i_dm_rdata  in  32  read word, valid with i_dm_ack

Behaviour:
- Opcodes: lb 100000, lh 100001, lw 100011, lbu 100100, lhu 100101, sb 101000, sh 101001, sw 101011. Any other opcode is not a memory op: no stall, no request.
- Reset: state IDLE; all outputs 0; timeout counter 0; latched fields 0.
- State IDLE: if i_mem_valid and memory op: latch opcode, addr[1:0], wdata; go ACCESS. o_stall=1 combinationally this cycle.
- State ACCESS: o_dm_req=1 (registered, stable until ack); o_stall=1; counter increments from 0.
  - i_dm_ack=1: for loads, register extended data into o_rdata with o_rdata_valid=1; go DONE.
  - No ack and counter==TIMEOUT-1: drop req; o_err=1; o_rdata=0; go DONE.
- State DONE: o_stall=0 so the pipeline advances exactly one cycle; i_mem_valid is ignored (same instruction); next state IDLE.
- Minimum latency with ack in first ACCESS cycle: 3 cycles (IDLE, ACCESS, DONE).
- Byte enables: sb -> 0001<<a[1:0]; sh -> 0011<<{a[1],0}; sw -> 1111; loads -> same masks, o_dm_we=0.
- Write data: sb -> {4{wdata[7:0]}}; sh -> {2{wdata[15:0]}}; sw -> wdata.
- Load extract:
  - Byte: lane a[1:0]; lb sign-extends bit 7, lbu zero-extends.
  - Half: lane a[1]; lh sign-extends bit 15, lhu zero-extends.
  - lw: whole word.
- Without MISALIGN_TRAP_EN, halfword a[0] and word a[1:0] are ignored (forced aligned).
- i_dm_ack outside ACCESS is ignored.
- Reset asserted mid-access: immediate return to IDLE, req drops, no pulses.

Optional Feature:
MISALIGN_TRAP_EN. When defined, IDLE checks alignment: halfword op with a[0]=1, or word op with a[1:0]!=0, goes straight to DONE with o_err=1, no o_dm_req and o_rdata=0. When not defined, misaligned addresses are silently aligned as above and o_err signals only timeout.

Decomposition:
- Shared package mips_mem_pkg: opcode constants (OP_LB..OP_SW), FSM state encoding (IDLE/ACCESS/DONE), and size encoding (BYTE/HALF/WORD).
- One natural sub-module, dmem_lane_align: purely combinational, produces be/wdata from size, addr[1:0], wdata, and extracted/extended rdata from size, signedness, addr[1:0], dm_rdata.

Test Plan:
- sb, addr 0x...03, wdata 0x12345678, ack after 2 cycles -> be=1000, dm_wdata=0x78787878, we=1, o_stall high for 3 cycles, then low 1 cycle.
- lb, addr 0x...02, rdata 0x00800000 -> o_rdata=0xFFFFFF80; lbu at the same address -> 0x00000080; o_rdata_valid pulse 1 cycle.
- lh, addr 0x...02, rdata 0x8001_1234 -> be=1100, o_rdata=0xFFFF8001; lw with ack in first ACCESS cycle -> 3-cycle total latency.
- No ack with TIMEOUT=4 -> req high exactly 4 cycles, o_err pulse, o_rdata=0, stall released in DONE.
- Reset pulled low during ACCESS -> req, stall and all outputs 0 asynchronously; the next op starts cleanly from IDLE.
- MISALIGN_TRAP_EN defined, sw at 0x...02 -> no req, o_err=1, stall for 1 cycle (IDLE) only. Undefined -> be=1111, dm_addr=0x...00.

Source files
------------

// File: rtl/mips_mem_pkg.sv
// mips_mem_pkg
// Shared definitions for the MEM-stage data-memory access path:
//   - load/store opcode constants (OP_LB..OP_SW)
//   - access FSM state encoding (IDLE / ACCESS / DONE)
//   - access size encoding (BYTE / HALF / WORD)
//   - decode_op(): opcode -> {is_mem, is_store, is_signed, size}
//   - is_misaligned(): used only when MISALIGN_TRAP_EN is defined
package mips_mem_pkg;

  localparam logic [5:0] OP_LB  = 6'b100000;
  localparam logic [5:0] OP_LH  = 6'b100001;
  localparam logic [5:0] OP_LW  = 6'b100011;
  localparam logic [5:0] OP_LBU = 6'b100100;
  localparam logic [5:0] OP_LHU = 6'b100101;
  localparam logic [5:0] OP_SB  = 6'b101000;
  localparam logic [5:0] OP_SH  = 6'b101001;
  localparam logic [5:0] OP_SW  = 6'b101011;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    DONE   = 2'd2
  } state_t;

  typedef enum logic [1:0] {
    BYTE = 2'd0,
    HALF = 2'd1,
    WORD = 2'd2
  } size_t;

  typedef struct packed {
    logic  is_mem;
    logic  is_store;
    logic  is_signed;
    size_t size;
  } mem_op_t;

  function automatic mem_op_t decode_op(input logic [5:0] op);
    mem_op_t d;
    d = '0;
    case (op)
      OP_LB:  begin d.is_mem = 1'b1; d.is_signed = 1'b1; d.size = BYTE; end
      OP_LH:  begin d.is_mem = 1'b1; d.is_signed = 1'b1; d.size = HALF; end
      OP_LW:  begin d.is_mem = 1'b1; d.size = WORD; end
      OP_LBU: begin d.is_mem = 1'b1; d.size = BYTE; end
      OP_LHU: begin d.is_mem = 1'b1; d.size = HALF; end
      OP_SB:  begin d.is_mem = 1'b1; d.is_store = 1'b1; d.size = BYTE; end
      OP_SH:  begin d.is_mem = 1'b1; d.is_store = 1'b1; d.size = HALF; end
      OP_SW:  begin d.is_mem = 1'b1; d.is_store = 1'b1; d.size = WORD; end
      default: d = '0;
    endcase
    return d;
  endfunction

  function automatic logic is_misaligned(input size_t sz, input logic [1:0] a);
    logic m;
    m = 1'b0;
    case (sz)
      HALF:    m = a[0];
      WORD:    m = (a != 2'b00);
      default: m = 1'b0;
    endcase
    return m;
  endfunction

endpackage

// File: rtl/dmem_access_ctrl_lane.sv
// dmem_lane_align
// Purely combinational byte-lane steering for the data memory port.
// Store side: byte enables and lane-replicated write data.
// Load side : lane extraction plus sign/zero extension.
// Halfword ignores addr[0]; word ignores addr[1:0] (forced alignment).
// Ports:
//   i_size     access size (BYTE/HALF/WORD)
//   i_signed   1 = sign-extend loads
//   i_addr_lo  byte offset within the word
//   i_wdata    store data (rt)
//   i_dm_rdata raw word from memory
//   o_be       byte enables, bit i = lane i
//   o_wdata    lane-replicated write data
//   o_rdata    extracted, extended load data
module dmem_lane_align
  import mips_mem_pkg::*;
(
  input  size_t       i_size,
  input  logic        i_signed,
  input  logic [1:0]  i_addr_lo,
  input  logic [31:0] i_wdata,
  input  logic [31:0] i_dm_rdata,
  output logic [3:0]  o_be,
  output logic [31:0] o_wdata,
  output logic [31:0] o_rdata
);

  logic [7:0]  w_byte;
  logic [15:0] w_half;

  always_comb begin
    w_byte = 8'h00;
    case (i_addr_lo)
      2'd0:    w_byte = i_dm_rdata[7:0];
      2'd1:    w_byte = i_dm_rdata[15:8];
      2'd2:    w_byte = i_dm_rdata[23:16];
      default: w_byte = i_dm_rdata[31:24];
    endcase
    w_half = i_addr_lo[1] ? i_dm_rdata[31:16] : i_dm_rdata[15:0];
  end

  always_comb begin
    o_be    = 4'b0000;
    o_wdata = 32'h0;
    o_rdata = 32'h0;
    case (i_size)
      BYTE: begin
        o_be    = 4'b0001 << i_addr_lo;
        o_wdata = {4{i_wdata[7:0]}};
        o_rdata = {{24{i_signed & w_byte[7]}}, w_byte};
      end
      HALF: begin
        o_be    = i_addr_lo[1] ? 4'b1100 : 4'b0011;
        o_wdata = {2{i_wdata[15:0]}};
        o_rdata = {{16{i_signed & w_half[15]}}, w_half};
      end
      default: begin
        o_be    = 4'b1111;
        o_wdata = i_wdata;
        o_rdata = i_dm_rdata;
      end
    endcase
  end

endmodule

// File: rtl/dmem_access_ctrl.sv
// dmem_access_ctrl
// MEM-stage data-memory access controller. Decodes load/store opcodes,
// runs a req/ack handshake to a variable-latency memory and stalls the
// pipeline until the access completes or times out.
// Optional build macro: MISALIGN_TRAP_EN (misaligned half/word -> o_err,
// no memory request). Without it, misaligned addresses are forced aligned.
// Handshake: o_dm_req rises on entry to ACCESS and, with we/be/addr/wdata,
// stays stable until the cycle in which i_dm_ack is sampled high (or the
// timeout fires); i_dm_ack outside ACCESS is ignored.
// Ports:
//   i_clk, i_reset_n          clock, async active-low reset
//   i_mem_valid, i_opcode     MEM-stage instruction
//   i_addr, i_wdata           effective address, store data
//   o_stall                   freeze IF..MEM
//   o_rdata, o_rdata_valid    extended load result + 1-cycle pulse
//   o_err                     timeout / misalign pulse
//   o_dm_*                    memory request side
//   i_dm_ack, i_dm_rdata      memory response side
//   o_dbg_state               FSM state for observation
module dmem_access_ctrl
  import mips_mem_pkg::*;
#(
  parameter int ADDR_W  = 32,
  parameter int TIMEOUT = 255
) (
  input  logic              i_clk,
  input  logic              i_reset_n,
  input  logic              i_mem_valid,
  input  logic [5:0]        i_opcode,
  input  logic [ADDR_W-1:0] i_addr,
  input  logic [31:0]       i_wdata,
  output logic              o_stall,
  output logic [31:0]       o_rdata,
  output logic              o_rdata_valid,
  output logic              o_err,
  output logic              o_dm_req,
  output logic              o_dm_we,
  output logic [3:0]        o_dm_be,
  output logic [ADDR_W-1:0] o_dm_addr,
  output logic [31:0]       o_dm_wdata,
  input  logic              i_dm_ack,
  input  logic [31:0]       i_dm_rdata,
  output state_t            o_dbg_state
);

  localparam logic [7:0] TO_LAST = 8'(TIMEOUT - 1);

  state_t            r_state, w_next_state;
  mem_op_t           r_op;
  logic [ADDR_W-1:0] r_addr;
  logic [31:0]       r_wdata;
  logic [7:0]        r_cnt;
  logic              r_dm_req;
  logic [31:0]       r_rdata;
  logic              r_rdata_valid;
  logic              r_err;

  mem_op_t     w_dec;
  logic        w_start;
  logic        w_misalign;
  logic        w_timeout;
  logic [3:0]  w_be;
  logic [31:0] w_wdata;
  logic [31:0] w_ext;

  assign w_dec = decode_op(i_opcode);
  // Gated by reset so no stall is requested while the pipeline is in reset.
  assign w_start = i_reset_n & i_mem_valid & w_dec.is_mem;

`ifdef MISALIGN_TRAP_EN
  assign w_misalign = is_misaligned(w_dec.size, i_addr[1:0]);
`else
  assign w_misalign = 1'b0;
`endif

  assign w_timeout = (r_cnt == TO_LAST) && !i_dm_ack;

  dmem_lane_align u_lane (
    .i_size     (r_op.size),
    .i_signed   (r_op.is_signed),
    .i_addr_lo  (r_addr[1:0]),
    .i_wdata    (r_wdata),
    .i_dm_rdata (i_dm_rdata),
    .o_be       (w_be),
    .o_wdata    (w_wdata),
    .o_rdata    (w_ext)
  );

  always_comb begin
    w_next_state = r_state;
    o_stall      = 1'b0;
    case (r_state)
      IDLE: begin
        o_stall = w_start;
        if (w_start) w_next_state = w_misalign ? DONE : ACCESS;
      end
      ACCESS: begin
        o_stall = 1'b1;
        if (i_dm_ack || w_timeout) w_next_state = DONE;
      end
      // DONE lets the pipeline advance one cycle; i_mem_valid still shows
      // the same instruction, so it must not start a new access.
      DONE:    w_next_state = IDLE;
      default: w_next_state = IDLE;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      r_state       <= IDLE;
      r_op          <= '0;
      r_addr        <= '0;
      r_wdata       <= '0;
      r_cnt         <= '0;
      r_dm_req      <= 1'b0;
      r_rdata       <= '0;
      r_rdata_valid <= 1'b0;
      r_err         <= 1'b0;
    end else begin
      r_state       <= w_next_state;
      r_rdata_valid <= 1'b0;
      r_err         <= 1'b0;
      case (r_state)
        IDLE: begin
          if (w_start) begin
            r_op    <= w_dec;
            r_addr  <= i_addr;
            r_wdata <= i_wdata;
            r_cnt   <= '0;
            if (w_misalign) begin
              r_err   <= 1'b1;
              r_rdata <= '0;
            end else begin
              r_dm_req <= 1'b1;
            end
          end
        end
        ACCESS: begin
          if (i_dm_ack) begin
            r_dm_req <= 1'b0;
            if (!r_op.is_store) begin
              r_rdata       <= w_ext;
              r_rdata_valid <= 1'b1;
            end
          end else if (w_timeout) begin
            r_dm_req <= 1'b0;
            r_err    <= 1'b1;
            r_rdata  <= '0;
          end else begin
            r_cnt <= r_cnt + 8'd1;
          end
        end
        default: ;
      endcase
    end
  end

  // Request-side fields come from latched registers and are zero whenever
  // no request is outstanding.
  assign o_dm_req      = r_dm_req;
  assign o_dm_we       = r_dm_req & r_op.is_store;
  assign o_dm_be       = r_dm_req ? w_be : 4'b0000;
  assign o_dm_addr     = r_dm_req ? {r_addr[ADDR_W-1:2], 2'b00} : '0;
  assign o_dm_wdata    = (r_dm_req & r_op.is_store) ? w_wdata : 32'h0;
  assign o_rdata       = r_rdata;
  assign o_rdata_valid = r_rdata_valid;
  assign o_err         = r_err;
  assign o_dbg_state   = r_state;

endmodule

// File: tb/tb_dmem_access_ctrl.sv
module tb_dmem_access_ctrl;
  import mips_mem_pkg::*;

  localparam int ADDR_W  = 32;
  localparam int TIMEOUT = 4;

  // clock / reset
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic              mem_valid = 1'b0;
  logic [5:0]        opcode = '0;
  logic [ADDR_W-1:0] addr_i = '0;
  logic [31:0]       wdata_i = '0;
  logic              dm_ack = 1'b0;
  logic [31:0]       dm_rdata = '0;
  logic              o_stall, o_rdata_valid, o_err, o_dm_req, o_dm_we;
  logic [31:0]       o_rdata, o_dm_wdata;
  logic [3:0]        o_dm_be;
  logic [ADDR_W-1:0] o_dm_addr;
  state_t            o_dbg_state;

  int checks = 0;
  int errors = 0;

  dmem_access_ctrl #(.ADDR_W(ADDR_W), .TIMEOUT(TIMEOUT)) dut (
    .i_clk(clk), .i_reset_n(rst_n), .i_mem_valid(mem_valid), .i_opcode(opcode),
    .i_addr(addr_i), .i_wdata(wdata_i), .o_stall(o_stall), .o_rdata(o_rdata),
    .o_rdata_valid(o_rdata_valid), .o_err(o_err), .o_dm_req(o_dm_req),
    .o_dm_we(o_dm_we), .o_dm_be(o_dm_be), .o_dm_addr(o_dm_addr),
    .o_dm_wdata(o_dm_wdata), .i_dm_ack(dm_ack), .i_dm_rdata(dm_rdata),
    .o_dbg_state(o_dbg_state)
  );

  typedef struct {
    int          n_stall;
    int          n_req;
    logic [31:0] rd;
    logic        rv;
    logic        er;
    logic        rv_after;
    logic        er_after;
    logic        idle_after;
    logic [3:0]  be;
    logic        we;
    logic [31:0] dwd;
    logic [31:0] dad;
    logic        to;
  } res_t;

  // Driver: issue one MEM-stage op from IDLE (called #1 after a rising edge),
  // ack on the ack_at-th request cycle (0 = never), record what was seen.
  // i_mem_valid is held through DONE like a frozen pipeline would.
  task automatic run_op(input logic [5:0] op, input logic [31:0] addr,
                        input logic [31:0] wd, input logic [31:0] rdv,
                        input int ack_at, output res_t r);
    r.n_stall = 0; r.n_req = 0; r.rd = '0; r.rv = 0; r.er = 0;
    r.rv_after = 0; r.er_after = 0; r.idle_after = 0;
    r.be = '0; r.we = 0; r.dwd = '0; r.dad = '0; r.to = 1;
    mem_valid = 1'b1; opcode = op; addr_i = addr; wdata_i = wd;
    for (int c = 0; c < 40; c++) begin
      #1;
      if (!o_stall) begin
        r.rd = o_rdata; r.rv = o_rdata_valid; r.er = o_err; r.to = 0;
        break;
      end
      r.n_stall++;
      if (o_dm_req) begin
        r.n_req++;
        if (r.n_req == 1) begin
          r.be = o_dm_be; r.we = o_dm_we; r.dwd = o_dm_wdata; r.dad = o_dm_addr;
        end
        if (r.n_req == ack_at) begin dm_ack = 1'b1; dm_rdata = rdv; end
      end
      @(posedge clk); #1;
      dm_ack = 1'b0; dm_rdata = '0;
    end
    @(posedge clk); #1;
    r.rv_after = o_rdata_valid; r.er_after = o_err;
    r.idle_after = (o_dbg_state == IDLE) && !o_dm_req;
    mem_valid = 1'b0; opcode = '0;
  endtask

  task automatic test_reset();
    #1;
    checks++;
    if (o_stall !== 0 || o_rdata !== 0 || o_rdata_valid !== 0 || o_err !== 0 ||
        o_dm_req !== 0 || o_dm_we !== 0 || o_dm_be !== 0 || o_dm_addr !== 0 ||
        o_dm_wdata !== 0) begin
      errors++;
      $display("FAIL reset_outputs: stall=%b rd=%h rv=%b err=%b req=%b we=%b be=%b addr=%h wd=%h, all must be 0",
               o_stall, o_rdata, o_rdata_valid, o_err, o_dm_req, o_dm_we, o_dm_be, o_dm_addr, o_dm_wdata);
    end
    checks++;
    if (o_dbg_state !== IDLE) begin errors++; $display("FAIL reset_state: got %0d exp IDLE", o_dbg_state); end
    #20 rst_n = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_sb();
    res_t r;
    run_op(OP_SB, 32'h0000_1003, 32'h1234_5678, 32'h0, 2, r);
    checks++; if (r.to !== 0) begin errors++; $display("FAIL sb_timeout: stall never released"); end
    checks++; if (r.n_stall != 3) begin errors++; $display("FAIL sb_stall_cycles: got %0d exp 3", r.n_stall); end
    checks++; if (r.n_req != 2) begin errors++; $display("FAIL sb_req_cycles: got %0d exp 2", r.n_req); end
    checks++; if (r.be !== 4'b1000) begin errors++; $display("FAIL sb_be: got %b exp 1000", r.be); end
    checks++; if (r.dwd !== 32'h7878_7878) begin errors++; $display("FAIL sb_wdata: got %h exp 78787878", r.dwd); end
    checks++; if (r.we !== 1'b1) begin errors++; $display("FAIL sb_we: got %b exp 1", r.we); end
    checks++; if (r.dad !== 32'h0000_1000) begin errors++; $display("FAIL sb_addr: got %h exp 00001000", r.dad); end
    checks++; if (r.rv !== 0 || r.er !== 0) begin errors++; $display("FAIL sb_no_pulse: rv=%b err=%b exp 0 0", r.rv, r.er); end
    checks++; if (r.idle_after !== 1) begin errors++; $display("FAIL sb_done_ignores_valid: got %b exp 1", r.idle_after); end
  endtask

  task automatic test_loads();
    res_t r;
    logic [5:0]  ops [6];
    logic [31:0] adr [6];
    logic [31:0] mem [6];
    logic [3:0]  ebe [6];
    logic [31:0] exp_rd [6];
    ops[0] = OP_LB;  adr[0] = 32'h2002; mem[0] = 32'h0080_0000; ebe[0] = 4'b0100; exp_rd[0] = 32'hFFFF_FF80;
    ops[1] = OP_LBU; adr[1] = 32'h2002; mem[1] = 32'h0080_0000; ebe[1] = 4'b0100; exp_rd[1] = 32'h0000_0080;
    ops[2] = OP_LH;  adr[2] = 32'h2002; mem[2] = 32'h8001_1234; ebe[2] = 4'b1100; exp_rd[2] = 32'hFFFF_8001;
    ops[3] = OP_LHU; adr[3] = 32'h2002; mem[3] = 32'h8001_1234; ebe[3] = 4'b1100; exp_rd[3] = 32'h0000_8001;
    ops[4] = OP_LB;  adr[4] = 32'h2000; mem[4] = 32'hAABB_CC7F; ebe[4] = 4'b0001; exp_rd[4] = 32'h0000_007F;
    ops[5] = OP_LW;  adr[5] = 32'h2004; mem[5] = 32'hDEAD_BEEF; ebe[5] = 4'b1111; exp_rd[5] = 32'hDEAD_BEEF;
    for (int i = 0; i < 6; i++) begin
      run_op(ops[i], adr[i], 32'hFFFF_FFFF, mem[i], 1, r);
      checks++; if (r.to !== 0 || r.n_stall != 2) begin errors++; $display("FAIL load%0d_latency: stall=%0d to=%b exp 2 0", i, r.n_stall, r.to); end
      checks++; if (r.be !== ebe[i] || r.we !== 0) begin errors++; $display("FAIL load%0d_be: be=%b we=%b exp %b 0", i, r.be, r.we, ebe[i]); end
      checks++; if (r.rd !== exp_rd[i] || r.rv !== 1) begin errors++; $display("FAIL load%0d_rdata: got %h v=%b exp %h v=1", i, r.rd, r.rv, exp_rd[i]); end
      checks++; if (r.rv_after !== 0 || r.er !== 0) begin errors++; $display("FAIL load%0d_pulse: rv_after=%b err=%b exp 0 0", i, r.rv_after, r.er); end
    end
  endtask

  task automatic test_timeout();
    res_t r;
    run_op(OP_LW, 32'h0000_3000, 32'h0, 32'h0, 0, r);
    checks++; if (r.to !== 0) begin errors++; $display("FAIL to_hang: stall never released"); end
    checks++; if (r.n_req != TIMEOUT) begin errors++; $display("FAIL to_req_cycles: got %0d exp %0d", r.n_req, TIMEOUT); end
    checks++; if (r.n_stall != TIMEOUT + 1) begin errors++; $display("FAIL to_stall_cycles: got %0d exp %0d", r.n_stall, TIMEOUT + 1); end
    checks++; if (r.er !== 1 || r.rd !== 32'h0 || r.rv !== 0) begin errors++; $display("FAIL to_err: err=%b rd=%h rv=%b exp 1 0 0", r.er, r.rd, r.rv); end
    checks++; if (r.er_after !== 0) begin errors++; $display("FAIL to_err_pulse: got %b exp 0", r.er_after); end
  endtask

  task automatic test_non_mem();
    mem_valid = 1'b1; opcode = 6'b000000; addr_i = 32'h10; dm_ack = 1'b1;
    for (int i = 0; i < 3; i++) begin
      #1;
      checks++;
      if (o_stall !== 0 || o_dm_req !== 0 || o_rdata_valid !== 0 || o_dbg_state !== IDLE) begin
        errors++;
        $display("FAIL non_mem_%0d: stall=%b req=%b rv=%b state=%0d exp 0 0 0 IDLE", i, o_stall, o_dm_req, o_rdata_valid, o_dbg_state);
      end
      @(posedge clk); #1;
    end
    mem_valid = 1'b0; opcode = '0; dm_ack = 1'b0;
  endtask

  task automatic test_reset_mid_access();
    res_t r;
    mem_valid = 1'b1; opcode = OP_LW; addr_i = 32'h5000;
    @(posedge clk); #1;
    @(posedge clk); #1;
    checks++; if (o_dm_req !== 1) begin errors++; $display("FAIL rst_mid_pre: req=%b exp 1", o_dm_req); end
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if (o_dm_req !== 0 || o_stall !== 0 || o_dm_be !== 0 || o_err !== 0 ||
        o_rdata_valid !== 0 || o_dbg_state !== IDLE) begin
      errors++;
      $display("FAIL rst_mid_async: req=%b stall=%b be=%b err=%b rv=%b state=%0d exp all 0/IDLE",
               o_dm_req, o_stall, o_dm_be, o_err, o_rdata_valid, o_dbg_state);
    end
    mem_valid = 1'b0; opcode = '0;
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;
    checks++; if (o_err !== 0 || o_rdata_valid !== 0 || o_dm_req !== 0) begin errors++; $display("FAIL rst_mid_after: err=%b rv=%b req=%b exp 0", o_err, o_rdata_valid, o_dm_req); end
    run_op(OP_SW, 32'h0000_3004, 32'hCAFE_F00D, 32'h0, 1, r);
    checks++;
    if (r.to !== 0 || r.n_stall != 2 || r.be !== 4'b1111 || r.dwd !== 32'hCAFE_F00D || r.dad !== 32'h3004) begin
      errors++;
      $display("FAIL rst_mid_next_op: stall=%0d be=%b wd=%h addr=%h exp 2 1111 cafef00d 00003004", r.n_stall, r.be, r.dwd, r.dad);
    end
  endtask

  task automatic test_misalign();
    res_t r;
    run_op(OP_SW, 32'h0000_4002, 32'h1122_3344, 32'h5555_5555, 1, r);
`ifdef MISALIGN_TRAP_EN
    checks++; if (r.n_req != 0 || r.n_stall != 1) begin errors++; $display("FAIL mis_sw_trap: req=%0d stall=%0d exp 0 1", r.n_req, r.n_stall); end
    checks++; if (r.er !== 1 || r.rd !== 32'h0) begin errors++; $display("FAIL mis_sw_err: err=%b rd=%h exp 1 0", r.er, r.rd); end
    run_op(OP_LH, 32'h0000_4001, 32'h0, 32'h5555_5555, 1, r);
    checks++; if (r.n_req != 0 || r.er !== 1 || r.rv !== 0) begin errors++; $display("FAIL mis_lh_trap: req=%0d err=%b rv=%b exp 0 1 0", r.n_req, r.er, r.rv); end
`else
    checks++; if (r.be !== 4'b1111 || r.dad !== 32'h4000 || r.dwd !== 32'h1122_3344) begin errors++; $display("FAIL mis_sw_align: be=%b addr=%h wd=%h exp 1111 00004000 11223344", r.be, r.dad, r.dwd); end
    checks++; if (r.er !== 0 || r.n_stall != 2) begin errors++; $display("FAIL mis_sw_noerr: err=%b stall=%0d exp 0 2", r.er, r.n_stall); end
    run_op(OP_SH, 32'h0000_4001, 32'hAAAA_3344, 32'h0, 1, r);
    checks++; if (r.be !== 4'b0011 || r.dwd !== 32'h3344_3344 || r.er !== 0) begin errors++; $display("FAIL mis_sh_align: be=%b wd=%h err=%b exp 0011 33443344 0", r.be, r.dwd, r.er); end
`endif
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_sb();
    test_loads();
    test_timeout();
    test_non_mem();
    test_reset_mid_access();
    test_misalign();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
